// File: rtl/axis_packet_fifo_if.sv
// AXI-Stream beat bundle shared by the input and output sides of axis_packet_fifo.
// The master drives the beat and tvalid; the slave drives tready.
interface axis_packet_fifo_if #(
   parameter int DATA_W = 32,
   parameter int USER_W = 1
);
   logic [DATA_W-1:0] tdata;
   logic [USER_W-1:0] tuser;
   logic              tlast;
   logic              tvalid;
   logic              tready;

   modport master (output tdata, output tuser, output tlast, output tvalid, input tready);
   modport slave  (input tdata, input tuser, input tlast, input tvalid, output tready);
endinterface

// File: rtl/axis_packet_fifo.sv
// DEPTH-entry AXI-Stream FIFO with a registered output stage and an optional
// store-and-forward mode that withholds frames until tlast and drops bad or oversize frames.
module axis_packet_fifo #(
   parameter int DATA_W      = 32,
   parameter int USER_W      = 1,
   parameter int DEPTH       = 16,
   parameter int PACKET_MODE = 0,
   parameter int DROP_BAD    = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   axis_packet_fifo_if.slave        s_axis,
   axis_packet_fifo_if.master       m_axis,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     drop
);
   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;
   localparam int EW = DATA_W + USER_W + 1;
   localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);
   localparam logic [PW-1:0] ONE_P   = PW'(1);

   localparam logic [0:0] ST_PASS    = 1'b0;
   localparam logic [0:0] ST_DISCARD = 1'b1;

   logic [EW-1:0] mem [DEPTH];

   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] commit_ptr_q, commit_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [0:0]    state_q, state_d;
   logic          out_valid_q, out_valid_d;
   logic [EW-1:0] out_beat_q, out_beat_d;
   logic          drop_q, drop_d;

   logic          full, accept, consume, load, wr_en;
   logic [EW-1:0] s_beat, rd_beat;

   assign s_beat  = {s_axis.tdata, s_axis.tuser, s_axis.tlast};
   assign rd_beat = mem[rd_ptr_q[AW-1:0]];

   // Ready looks only at registered pointers, so a read in this cycle cannot reopen a full memory.
   assign full          = (wr_ptr_q - rd_ptr_q) == DEPTH_P;
   assign s_axis.tready = !rst && (state_q == ST_DISCARD || !full);

   assign accept  = s_axis.tvalid && s_axis.tready;
   assign consume = out_valid_q && m_axis.tready;
   assign load    = (!out_valid_q || consume) && (rd_ptr_q != commit_ptr_q);
   assign wr_en   = accept && (state_q == ST_PASS);

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      wr_ptr_d     = wr_ptr_q;
      commit_ptr_d = commit_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      state_d      = state_q;
      out_valid_d  = out_valid_q;
      out_beat_d   = out_beat_q;
      drop_d       = 1'b0;

      if (load) begin
         out_beat_d  = rd_beat;
         out_valid_d = 1'b1;
         rd_ptr_d    = rd_ptr_q + ONE_P;
      end else if (consume) begin
         out_valid_d = 1'b0;
      end

      if (wr_en) begin
         wr_ptr_d = wr_ptr_q + ONE_P;
      end

      if (PACKET_MODE == 0) begin
         commit_ptr_d = wr_ptr_d;
      end else if (state_q == ST_PASS) begin
         if (wr_en && s_axis.tlast) begin
            if (DROP_BAD != 0 && s_axis.tuser[0]) begin
               wr_ptr_d = commit_ptr_q;
               drop_d   = 1'b1;
            end else begin
               commit_ptr_d = wr_ptr_d;
            end
         end else if ((wr_ptr_d - rd_ptr_d) == DEPTH_P && commit_ptr_q == rd_ptr_d) begin
            // Memory about to be filled by one unterminated frame: it can never be committed.
            wr_ptr_d = commit_ptr_q;
            state_d  = ST_DISCARD;
         end
      end else if (accept && s_axis.tlast) begin
         drop_d  = 1'b1;
         state_d = ST_PASS;
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
      if (rst) begin
         wr_ptr_q     <= '0;
         commit_ptr_q <= '0;
         rd_ptr_q     <= '0;
         state_q      <= ST_PASS;
         out_valid_q  <= 1'b0;
         out_beat_q   <= '0;
         drop_q       <= 1'b0;
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         commit_ptr_q <= commit_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         state_q      <= state_d;
         out_valid_q  <= out_valid_d;
         out_beat_q   <= out_beat_d;
         drop_q       <= drop_d;
      end
   end

   // NOTE: the storage array has no reset; pointers alone decide which entries are meaningful.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_ptr_q[AW-1:0]] <= s_beat;
      end
   end

   assign m_axis.tvalid = out_valid_q;
   assign {m_axis.tdata, m_axis.tuser, m_axis.tlast} = out_beat_q;
   assign level = (wr_ptr_q - rd_ptr_q) + PW'(out_valid_q);
   assign drop  = drop_q;
endmodule
